seven_seg_scanner: RTL

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It consumes the 16-bit BCD word chosen by the display mode selector (clock, stopwatch or alarm set). It scans one digit at a time, decodes BCD to segments, and applies per-digit blink, decimal points and hour-tens leading-zero suppression. It is the last stage before the board pins.

---
 rtl/seven_seg_scanner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner: frame-synchronous snapshot,
// BCD decode, per-digit blink, decimal points and hour-tens zero suppression.
module seven_seg_scanner #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] bcd_in,
   input  logic [3:0]  blink_mask,
   input  logic [3:0]  dp_mask,
   input  logic        lz_blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_TC = BLK_W'(BLINK_DIV - 1);

   logic [PRE_W-1:0] r_pre;
   logic [1:0]       r_idx;
   logic [BLK_W-1:0] r_blink_cnt;
   logic             r_blink_ph;
   logic [15:0]      r_snap_bcd;
   logic [3:0]       r_snap_blink;
   logic [3:0]       r_snap_dp;
   logic             r_snap_lz;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;

   logic             w_pre_tc;
   logic [3:0]       w_v;
   logic             w_blank;
   logic [6:0]       w_seg;

   assign w_pre_tc = (r_pre == PRE_TC);

   // Digit value for the slot being scanned.
   always_comb begin
      w_v = r_snap_bcd[3:0];
      case (r_idx)
         2'd0: w_v = r_snap_bcd[3:0];
         2'd1: w_v = r_snap_bcd[7:4];
         2'd2: w_v = r_snap_bcd[11:8];
         2'd3: w_v = r_snap_bcd[15:12];
         default: w_v = r_snap_bcd[3:0];
      endcase
   end

   // First cycle of each slot is dark so the previous digit cannot ghost.
   assign w_blank = (r_pre == '0)
                  | (r_blink_ph & r_snap_blink[r_idx])
                  | ((r_idx == 2'd3) & r_snap_lz & (w_v == 4'd0));

   // Active-low gfedcba; non-BCD nibbles show a dash.
   always_comb begin
      w_seg = 7'b0111111;
      case (w_v)
         4'd0: w_seg = 7'b1000000;
         4'd1: w_seg = 7'b1111001;
         4'd2: w_seg = 7'b0100100;
         4'd3: w_seg = 7'b0110000;
         4'd4: w_seg = 7'b0011001;
         4'd5: w_seg = 7'b0010010;
         4'd6: w_seg = 7'b0000010;
         4'd7: w_seg = 7'b1111000;
         4'd8: w_seg = 7'b0000000;
         4'd9: w_seg = 7'b0010000;
         default: w_seg = 7'b0111111;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre <= '0;
         r_idx <= 2'd0;
      end else if (w_pre_tc) begin
         r_pre <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_pre <= r_pre + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blink_cnt <= '0;
         r_blink_ph  <= 1'b0;
      end else if (r_blink_cnt == BLK_TC) begin
         r_blink_cnt <= '0;
         r_blink_ph  <= ~r_blink_ph;
      end else begin
         r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
   end

   // Inputs are sampled only at the end of a frame to avoid tearing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_snap_bcd   <= 16'h0000;
         r_snap_blink <= 4'h0;
         r_snap_dp    <= 4'h0;
         r_snap_lz    <= 1'b0;
      end else if (w_pre_tc && (r_idx == 2'd3)) begin
         r_snap_bcd   <= bcd_in;
         r_snap_blink <= blink_mask;
         r_snap_dp    <= dp_mask;
         r_snap_lz    <= lz_blank;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_an  <= 4'b1111;
         r_seg <= 7'b1111111;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
         r_seg <= w_seg;
         r_dp  <= ~r_snap_dp[r_idx];
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule
